// File: rtl/mfp_ahb_intc_if.sv
// AHB-Lite slave port bundle for the interrupt controller.
// A transfer is accepted in the address phase when HSEL & HTRANS[1]. The data phase is the next cycle.
// HREADY is always 1 and HRESP is always OKAY, so no transfer is ever stalled or rejected.
interface mfp_ahb_intc_if #(
  parameter int HADDR_W = 6
);
  logic               HSEL;
  logic [HADDR_W-1:0] HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [31:0]        HWDATA;
  logic [31:0]        HRDATA;
  logic               HREADY;
  logic               HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller with per-source sync, polarity, edge/level detect, mask and routing.
// Drives the core's SI_Int lines from registered, priority-visible pending state.
module mfp_ahb_intc #(
  parameter int N_SRC   = 8,
  parameter int N_OUT   = 8,
  parameter int HADDR_W = 6
) (
  input  logic             HCLK,
  input  logic             SI_Reset,
  mfp_ahb_intc_if.slave    ahb,
  input  logic [N_SRC-1:0] IRQ_SRC,
  output logic [N_OUT-1:0] SI_Int
);
  localparam int IDX_W = HADDR_W - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_MODE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_POL     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_ENABLE  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_PENDING = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_RAW     = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(6);

  // Bus data-phase state.
  logic             dp_valid;
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;

  // Programmable registers.
  logic             gen;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pol;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] pending;
  logic [3:0]       route [N_SRC];

  // Input path.
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] lvl;
  logic [N_SRC-1:0] rise;

  logic             wr;
  logic [N_SRC-1:0] wdata_src;
  logic [N_SRC-1:0] mode_next;
  logic [N_SRC-1:0] pol_next;
  logic [N_SRC-1:0] changed;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] active;
  logic [N_OUT-1:0] irq_next;
  logic             id_valid;
  logic [4:0]       id_num;
  logic [31:0]      rdata;

  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[1:0], ahb.HTRANS[0]};

  assign ahb.HREADY = 1'b1;
  assign ahb.HRESP  = 1'b0;
  assign ahb.HRDATA = rdata;

  assign wr        = dp_valid & dp_write;
  assign wdata_src = ahb.HWDATA[N_SRC-1:0];
  assign mode_next = (wr && dp_idx == IDX_MODE) ? wdata_src : mode;
  assign pol_next  = (wr && dp_idx == IDX_POL)  ? wdata_src : pol;
  assign changed   = (mode ^ mode_next) | (pol ^ pol_next);
  assign w1c       = (wr && dp_idx == IDX_PENDING) ? wdata_src : '0;

  assign lvl    = sync2 ^ pol;
  assign rise   = lvl & ~prev;
  assign active = pending & enable;

  // A fresh edge beats a same-cycle W1C; a MODE/POL change wipes the affected bits.
  assign pending_next = ~changed & ((mode & ((pending & ~w1c) | rise)) | (~mode & lvl));

  always_comb begin
    id_valid = 1'b0;
    id_num   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_valid = 1'b1;
        id_num   = 5'(i);
      end
    end
  end

  always_comb begin
    irq_next = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (active[i] && route[i] == 4'(k)) irq_next[k] = 1'b1;
      end
    end
    if (!gen) irq_next = '0;
  end

  always_comb begin
    rdata = '0;
    if (dp_valid && !dp_write) begin
      case (dp_idx)
        IDX_CTRL:    rdata = {31'b0, gen};
        IDX_MODE:    rdata = 32'(mode);
        IDX_POL:     rdata = 32'(pol);
        IDX_ENABLE:  rdata = 32'(enable);
        IDX_PENDING: rdata = 32'(pending);
        IDX_RAW:     rdata = 32'(lvl);
        IDX_ID:      rdata = {id_valid, 26'b0, id_num};
        default: begin
          // Route words: 8 nibbles per word, source i lives in word i/8.
          for (int i = 0; i < N_SRC; i++) begin
            if (dp_idx == IDX_W'(8 + i / 8)) rdata[(i % 8) * 4 +: 4] = route[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      gen      <= 1'b0;
      mode     <= '0;
      pol      <= '0;
      enable   <= '0;
      pending  <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      SI_Int   <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        route[i] <= (i < N_OUT) ? 4'(i) : 4'hF;
      end
    end else begin
      dp_valid <= ahb.HSEL & ahb.HTRANS[1];
      dp_write <= ahb.HWRITE;
      dp_idx   <= ahb.HADDR[HADDR_W-1:2];

      if (wr && dp_idx == IDX_CTRL)   gen    <= ahb.HWDATA[0];
      if (wr && dp_idx == IDX_ENABLE) enable <= wdata_src;
      mode <= mode_next;
      pol  <= pol_next;
      for (int i = 0; i < N_SRC; i++) begin
        if (wr && dp_idx == IDX_W'(8 + i / 8)) route[i] <= ahb.HWDATA[(i % 8) * 4 +: 4];
      end

      sync1   <= IRQ_SRC;
      sync2   <= sync1;
      // Reloading prev with the new polarity keeps a POL write from looking like an edge.
      prev    <= sync2 ^ pol_next;
      pending <= pending_next;
      SI_Int  <= irq_next;
    end
  end
endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Directed bench for mfp_ahb_intc: register reset values, level/edge paths, collisions,
// routing/priority, polarity change and reset during a write data phase.
module tb_mfp_ahb_intc;
  localparam logic [5:0] A_CTRL    = 6'h00;
  localparam logic [5:0] A_MODE    = 6'h04;
  localparam logic [5:0] A_POL     = 6'h08;
  localparam logic [5:0] A_ENABLE  = 6'h0C;
  localparam logic [5:0] A_PENDING = 6'h10;
  localparam logic [5:0] A_RAW     = 6'h14;
  localparam logic [5:0] A_ID      = 6'h18;
  localparam logic [5:0] A_ROUTE0  = 6'h20;
  localparam logic [5:0] A_ROUTE1  = 6'h24;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic [7:0]  si_int;
  logic [31:0] rd;
  int          checks = 0;
  int          failures = 0;

  mfp_ahb_intc_if #(.HADDR_W(6)) ahb ();

  mfp_ahb_intc #(.N_SRC(8), .N_OUT(8), .HADDR_W(6)) dut (
    .HCLK     (clk),
    .SI_Reset (rst),
    .ahb      (ahb),
    .IRQ_SRC  (irq),
    .SI_Int   (si_int)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic bus_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    irq = '0;
    bus_idle();
    ahb.HWDATA = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns in the data phase; the write lands on the next rising edge.
  task automatic ahb_write(input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = addr;
    @(negedge clk);
    bus_idle();
    ahb.HWDATA = data;
  endtask

  task automatic ahb_read(input logic [5:0] addr, output logic [31:0] data);
    @(negedge clk);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = addr;
    @(negedge clk);
    bus_idle();
    data = ahb.HRDATA;
  endtask

  task automatic test_reset();
    logic [5:0]  addrs [9];
    logic [31:0] exps  [9];
    addrs = '{A_CTRL, A_MODE, A_POL, A_ENABLE, A_PENDING, A_RAW, A_ID, A_ROUTE0, A_ROUTE1};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h76543210, 32'h0};
    reset_dut();
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL reset_si_int: got %h expected 00", si_int);
    end
    checks++;
    if (ahb.HREADY !== 1'b1 || ahb.HRESP !== 1'b0) begin
      failures++;
      $display("FAIL reset_hready_hresp: got %b/%b expected 1/0", ahb.HREADY, ahb.HRESP);
    end
    checks++;
    if (ahb.HRDATA !== 32'h0) begin
      failures++;
      $display("FAIL reset_hrdata_idle: got %h expected 00000000", ahb.HRDATA);
    end
    for (int i = 0; i < 9; i++) begin
      ahb_read(addrs[i], rd);
      checks++;
      if (rd !== exps[i]) begin
        failures++;
        $display("FAIL reset_reg_%h: got %h expected %h", addrs[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_level();
    ahb_write(A_CTRL, 32'h1);
    ahb_write(A_ENABLE, 32'h01);
    wait_edges(1);
    irq[0] = 1'b1;
    wait_edges(3);
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL level_rise_e2: got %h expected 00", si_int);
    end
    wait_edges(1);
    checks++;
    if (si_int !== 8'h01) begin
      failures++;
      $display("FAIL level_rise_e3: got %h expected 01", si_int);
    end
    ahb_read(A_ID, rd);
    checks++;
    if (rd !== 32'h80000000) begin
      failures++;
      $display("FAIL level_id: got %h expected 80000000", rd);
    end
    irq[0] = 1'b0;
    wait_edges(3);
    checks++;
    if (si_int !== 8'h01) begin
      failures++;
      $display("FAIL level_fall_e2: got %h expected 01", si_int);
    end
    wait_edges(1);
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL level_fall_e3: got %h expected 00", si_int);
    end
  endtask

  task automatic test_edge();
    ahb_write(A_MODE, 32'h04);
    ahb_write(A_ENABLE, 32'h04);
    wait_edges(1);
    irq[2] = 1'b1;
    wait_edges(1);
    irq[2] = 1'b0;
    wait_edges(4);
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h04) begin
      failures++;
      $display("FAIL edge_pending: got %h expected 00000004", rd);
    end
    wait_edges(5);
    checks++;
    if (si_int !== 8'h04) begin
      failures++;
      $display("FAIL edge_held: got %h expected 04", si_int);
    end
    ahb_write(A_PENDING, 32'h04);
    wait_edges(2);
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL edge_w1c_si_int: got %h expected 00", si_int);
    end
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL edge_w1c_pending: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_collision();
    // Rising IRQ one edge before the address phase puts the pending set on the W1C commit edge.
    irq[2] = 1'b1;
    ahb_write(A_PENDING, 32'h04);
    wait_edges(1);
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h04) begin
      failures++;
      $display("FAIL collision_set_wins: got %h expected 00000004", rd);
    end
    irq[2] = 1'b0;
    wait_edges(3);
    ahb_write(A_PENDING, 32'h04);
    wait_edges(2);
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL collision_later_w1c: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_route_priority();
    reset_dut();
    ahb_write(A_CTRL, 32'h1);
    ahb_write(A_ROUTE0, 32'h76343230);
    ahb_write(A_ENABLE, 32'h22);
    wait_edges(1);
    irq = 8'h22;
    wait_edges(5);
    checks++;
    if (si_int !== 8'h08) begin
      failures++;
      $display("FAIL route_shared_line: got %h expected 08", si_int);
    end
    ahb_read(A_ID, rd);
    checks++;
    if (rd !== 32'h80000001) begin
      failures++;
      $display("FAIL route_id_lowest: got %h expected 80000001", rd);
    end
    ahb_write(A_ROUTE0, 32'h763432F0);
    wait_edges(2);
    checks++;
    if (si_int !== 8'h08) begin
      failures++;
      $display("FAIL route_unrouted_src1: got %h expected 08", si_int);
    end
    ahb_read(A_ID, rd);
    checks++;
    if (rd !== 32'h80000001) begin
      failures++;
      $display("FAIL route_id_unrouted: got %h expected 80000001", rd);
    end
    ahb_read(A_ROUTE0, rd);
    checks++;
    if (rd !== 32'h763432F0) begin
      failures++;
      $display("FAIL route_readback: got %h expected 763432f0", rd);
    end
    ahb_write(A_ROUTE0, 32'h76F432F0);
    wait_edges(2);
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL route_all_unrouted: got %h expected 00", si_int);
    end
    irq = '0;
  endtask

  task automatic test_polarity();
    reset_dut();
    ahb_write(A_MODE, 32'h01);
    ahb_write(A_ENABLE, 32'h01);
    ahb_write(A_CTRL, 32'h1);
    wait_edges(3);
    ahb_write(A_POL, 32'h01);
    wait_edges(4);
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL pol_no_spurious_pending: got %h expected 00000000", rd);
    end
    checks++;
    if (si_int !== 8'h00) begin
      failures++;
      $display("FAIL pol_no_spurious_si_int: got %h expected 00", si_int);
    end
    ahb_read(A_RAW, rd);
    checks++;
    if (rd !== 32'h01) begin
      failures++;
      $display("FAIL pol_raw_inverted: got %h expected 00000001", rd);
    end
    irq[0] = 1'b1;
    wait_edges(4);
    irq[0] = 1'b0;
    wait_edges(4);
    ahb_read(A_PENDING, rd);
    checks++;
    if (rd !== 32'h01) begin
      failures++;
      $display("FAIL pol_active_low_edge: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    reset_dut();
    @(negedge clk);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = A_CTRL;
    @(negedge clk);
    bus_idle();
    ahb.HWDATA = 32'h1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_edges(2);
    ahb_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_aborts_write: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    irq = '0;
    ahb.HWDATA = '0;
    bus_idle();
    test_reset();
    test_level();
    test_edge();
    test_collision();
    test_route_priority();
    test_polarity();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
